// File: rtl/hazard_unit.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_unit
//  Purpose  : Pipeline hazard control for a 5-stage in-order core.
//             Detects load-use stalls and taken-branch flushes, drives the
//             PC/IF-ID enables and bubble controls, registers the operand
//             forwarding selects aligned with ID/EX, and keeps saturating
//             stall/flush event counters.
//  Revision : 1.0 - initial release
// ============================================================================
module hazard_unit #(
   parameter int reg_bits = 5,
   parameter int cnt_bits = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                valid_id,
   input  logic [reg_bits-1:0] rs1_id,
   input  logic [reg_bits-1:0] rs2_id,
   input  logic [reg_bits-1:0] rd_id,
   input  logic                mem_read_id,
   input  logic                reg_write_id,
   input  logic                branch_taken_ex,
   output logic                pc_write,
   output logic                if_id_write,
   output logic                if_id_flush,
   output logic                id_ex_flush,
   output logic [1:0]          fwd_a_ex,
   output logic [1:0]          fwd_b_ex,
   output logic [1:0]          state_o,
   output logic [cnt_bits-1:0] stall_count,
   output logic [cnt_bits-1:0] flush_count
);

   typedef enum logic [1:0] {
      ST_RUN   = 2'b00,
      ST_STALL = 2'b01,
      ST_FLUSH = 2'b10
   } state_t;

   localparam logic [1:0]          c_fwd_rf  = 2'b00;
   localparam logic [1:0]          c_fwd_mem = 2'b10;  // EX/MEM result
   localparam logic [1:0]          c_fwd_wb  = 2'b01;  // MEM/WB result
   localparam logic [cnt_bits-1:0] c_cnt_max = {cnt_bits{1'b1}};
   localparam logic [cnt_bits-1:0] c_cnt_one = {{(cnt_bits-1){1'b0}}, 1'b1};

   state_t r_state;
   state_t w_state_nxt;

   // Shadow copies of the instructions currently in EX and MEM
   logic                r_ex_valid;
   logic [reg_bits-1:0] r_ex_rd;
   logic                r_ex_mem_read;
   logic                r_ex_reg_write;
   logic                r_mem_valid;
   logic [reg_bits-1:0] r_mem_rd;
   logic                r_mem_reg_write;

   logic [1:0]          r_fwd_a;
   logic [1:0]          r_fwd_b;
   logic [cnt_bits-1:0] r_stall_count;
   logic [cnt_bits-1:0] r_flush_count;

   logic       w_branch;
   logic       w_load_use_raw;
   logic       w_stall;
   logic       w_bubble;
   logic       w_ex_can_fwd;
   logic       w_mem_can_fwd;
   logic [1:0] w_fwd_a;
   logic [1:0] w_fwd_b;

   // A branch seen while in reset is ignored; x0 is never a hazard source
   assign w_branch       = rst_n & branch_taken_ex;
   assign w_load_use_raw = rst_n & valid_id & r_ex_valid & r_ex_mem_read &
                           (r_ex_rd != '0) &
                           ((r_ex_rd == rs1_id) | (r_ex_rd == rs2_id));
   // Branch wins: the dependent instruction is being squashed anyway
   assign w_stall        = w_load_use_raw & ~w_branch;
   assign w_bubble       = w_branch | w_load_use_raw;

   assign w_ex_can_fwd  = r_ex_valid  & r_ex_reg_write  & (r_ex_rd  != '0);
   assign w_mem_can_fwd = r_mem_valid & r_mem_reg_write & (r_mem_rd != '0);

   // Forwarding source for each ID operand; the younger (EX) producer wins
   always_comb begin
      w_fwd_a = c_fwd_rf;
      w_fwd_b = c_fwd_rf;
      if (w_ex_can_fwd && (r_ex_rd == rs1_id))
         w_fwd_a = c_fwd_mem;
      else if (w_mem_can_fwd && (r_mem_rd == rs1_id))
         w_fwd_a = c_fwd_wb;
      if (w_ex_can_fwd && (r_ex_rd == rs2_id))
         w_fwd_b = c_fwd_mem;
      else if (w_mem_can_fwd && (r_mem_rd == rs2_id))
         w_fwd_b = c_fwd_wb;
   end

   // Next state and pipeline control outputs
   always_comb begin
      w_state_nxt = r_state;
      pc_write    = 1'b1;
      if_id_write = 1'b1;
      if_id_flush = 1'b0;
      id_ex_flush = 1'b0;

      if (w_branch) begin
         if_id_flush = 1'b1;
         id_ex_flush = 1'b1;
      end else if (w_stall) begin
         pc_write    = 1'b0;
         if_id_write = 1'b0;
         id_ex_flush = 1'b1;
      end

      case (r_state)
         ST_RUN: begin
            if (w_branch)
               w_state_nxt = ST_FLUSH;
            else if (w_stall)
               w_state_nxt = ST_STALL;
            else
               w_state_nxt = ST_RUN;
         end
         ST_STALL: w_state_nxt = w_branch ? ST_FLUSH : ST_RUN;
         ST_FLUSH: w_state_nxt = w_branch ? ST_FLUSH : ST_RUN;
         default:  w_state_nxt = ST_RUN;
      endcase
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_state <= ST_RUN;
      else
         r_state <= w_state_nxt;
   end

   // Shadow EX/MEM records and forwarding selects aligned with ID/EX
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ex_valid      <= 1'b0;
         r_ex_rd         <= '0;
         r_ex_mem_read   <= 1'b0;
         r_ex_reg_write  <= 1'b0;
         r_mem_valid     <= 1'b0;
         r_mem_rd        <= '0;
         r_mem_reg_write <= 1'b0;
         r_fwd_a         <= c_fwd_rf;
         r_fwd_b         <= c_fwd_rf;
      end else begin
         r_mem_valid     <= r_ex_valid;
         r_mem_rd        <= r_ex_rd;
         r_mem_reg_write <= r_ex_reg_write;
         if (w_bubble) begin
            r_ex_valid <= 1'b0;
            r_fwd_a    <= c_fwd_rf;
            r_fwd_b    <= c_fwd_rf;
         end else begin
            r_ex_valid     <= valid_id;
            r_ex_rd        <= rd_id;
            r_ex_mem_read  <= mem_read_id;
            r_ex_reg_write <= reg_write_id;
            r_fwd_a        <= w_fwd_a;
            r_fwd_b        <= w_fwd_b;
         end
      end
   end

   // Saturating event counters
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_stall_count <= '0;
         r_flush_count <= '0;
      end else begin
         if (w_stall && (r_stall_count != c_cnt_max))
            r_stall_count <= r_stall_count + c_cnt_one;
         if (w_branch && (r_flush_count != c_cnt_max))
            r_flush_count <= r_flush_count + c_cnt_one;
      end
   end

   assign state_o     = r_state;
   assign fwd_a_ex    = r_fwd_a;
   assign fwd_b_ex    = r_fwd_b;
   assign stall_count = r_stall_count;
   assign flush_count = r_flush_count;

endmodule
`default_nettype wire

// File: tb/tb_hazard_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hazard_unit
//  Purpose  : Self-checking bench for hazard_unit. A default-width instance
//             and a 2-bit-counter instance share one stimulus stream; both
//             are compared against an instruction-level pipeline model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_unit;

   localparam int RB = 5;
   localparam int CB = 16;
   localparam int CBS = 2;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          valid_id;
   logic [RB-1:0] rs1_id, rs2_id, rd_id;
   logic          mem_read_id, reg_write_id, branch_taken_ex;

   logic          pc_write, if_id_write, if_id_flush, id_ex_flush;
   logic [1:0]    fwd_a_ex, fwd_b_ex, state_o;
   logic [CB-1:0] stall_count, flush_count;

   logic          s_pc_write, s_if_id_write, s_if_id_flush, s_id_ex_flush;
   logic [1:0]    s_fwd_a_ex, s_fwd_b_ex, s_state_o;
   logic [CBS-1:0] s_stall_count, s_flush_count;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   hazard_unit #(.reg_bits(RB), .cnt_bits(CB)) dut (
      .clk(clk), .rst_n(rst_n), .valid_id(valid_id),
      .rs1_id(rs1_id), .rs2_id(rs2_id), .rd_id(rd_id),
      .mem_read_id(mem_read_id), .reg_write_id(reg_write_id),
      .branch_taken_ex(branch_taken_ex),
      .pc_write(pc_write), .if_id_write(if_id_write),
      .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
      .fwd_a_ex(fwd_a_ex), .fwd_b_ex(fwd_b_ex), .state_o(state_o),
      .stall_count(stall_count), .flush_count(flush_count)
   );

   hazard_unit #(.reg_bits(RB), .cnt_bits(CBS)) dut_s (
      .clk(clk), .rst_n(rst_n), .valid_id(valid_id),
      .rs1_id(rs1_id), .rs2_id(rs2_id), .rd_id(rd_id),
      .mem_read_id(mem_read_id), .reg_write_id(reg_write_id),
      .branch_taken_ex(branch_taken_ex),
      .pc_write(s_pc_write), .if_id_write(s_if_id_write),
      .if_id_flush(s_if_id_flush), .id_ex_flush(s_id_ex_flush),
      .fwd_a_ex(s_fwd_a_ex), .fwd_b_ex(s_fwd_b_ex), .state_o(s_state_o),
      .stall_count(s_stall_count), .flush_count(s_flush_count)
   );

   // ---------------- reference model (instruction-level) -------------------
   typedef struct {
      bit v;
      int rd;
      bit ld;
      bit wr;
   } instr_t;

   instr_t ex_m, mem_m;
   int st_m;            // 0 RUN, 1 STALL, 2 FLUSH
   int fa_m, fb_m;      // 2 = from EX/MEM, 1 = from MEM/WB, 0 = register file
   int stalls_m, flushes_m;

   function automatic bit writes(instr_t i, int r);
      return i.v && i.wr && i.rd != 0 && i.rd == r;
   endfunction

   function automatic int source_of(int r);
      if (writes(ex_m, r))  return 2;
      if (writes(mem_m, r)) return 1;
      return 0;
   endfunction

   function automatic bit load_use_now();
      return rst_n && valid_id && ex_m.v && ex_m.ld && ex_m.rd != 0 &&
             (ex_m.rd == int'(rs1_id) || ex_m.rd == int'(rs2_id));
   endfunction

   function automatic int sat(int n, int bits);
      int mx;
      mx = (1 << bits) - 1;
      return (n > mx) ? mx : n;
   endfunction

   task automatic model_reset();
      ex_m = '{0, 0, 0, 0};
      mem_m = '{0, 0, 0, 0};
      st_m = 0; fa_m = 0; fb_m = 0;
      stalls_m = 0; flushes_m = 0;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input bit v, input int r1, input int r2, input int rd,
                        input bit ld, input bit wr, input bit br);
      valid_id        = v;
      rs1_id          = RB'(r1);
      rs2_id          = RB'(r2);
      rd_id           = RB'(rd);
      mem_read_id     = ld;
      reg_write_id    = wr;
      branch_taken_ex = br;
   endtask

   // One clock: check same-cycle controls, advance model, check registered outputs
   task automatic cycle();
      bit b, l;
      int na, nb;
      #1;
      b  = rst_n && branch_taken_ex;
      l  = load_use_now() && !b;
      na = source_of(int'(rs1_id));
      nb = source_of(int'(rs2_id));
      check("pc_write",    {31'd0, pc_write},    {31'd0, !l});
      check("if_id_write", {31'd0, if_id_write}, {31'd0, !l});
      check("if_id_flush", {31'd0, if_id_flush}, {31'd0, b});
      check("id_ex_flush", {31'd0, id_ex_flush}, {31'd0, b || l});
      check("s_pc_write",  {31'd0, s_pc_write},  {31'd0, !l});
      @(posedge clk);
      if (!rst_n) begin
         model_reset();
      end else begin
         mem_m = ex_m;
         if (b || load_use_now()) begin
            ex_m.v = 0; fa_m = 0; fb_m = 0;
         end else begin
            ex_m = '{valid_id, int'(rd_id), mem_read_id, reg_write_id};
            fa_m = na; fb_m = nb;
         end
         if (b)      st_m = 2;
         else if (l) st_m = (st_m == 0) ? 1 : 0;
         else        st_m = 0;
         stalls_m  += l;
         flushes_m += b;
      end
      #1;
      check("state_o",       {30'd0, state_o},    32'(st_m));
      check("fwd_a_ex",      {30'd0, fwd_a_ex},   32'(fa_m));
      check("fwd_b_ex",      {30'd0, fwd_b_ex},   32'(fb_m));
      check("stall_count",   32'(stall_count),    32'(sat(stalls_m, CB)));
      check("flush_count",   32'(flush_count),    32'(sat(flushes_m, CB)));
      check("s_stall_count", 32'(s_stall_count),  32'(sat(stalls_m, CBS)));
      check("s_flush_count", 32'(s_flush_count),  32'(sat(flushes_m, CBS)));
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      drive(0, 0, 0, 0, 0, 0, 1);   // branch held high: must be ignored
      model_reset();
      repeat (2) cycle();
      rst_n = 1'b1;
   endtask

   // lw x5 followed by a dependent instruction, then the resolved retry
   task automatic load_use_event();
      drive(1, 1, 0, 5, 1, 1, 0); cycle();
      drive(1, 5, 2, 6, 0, 1, 0); cycle();
      cycle();
   endtask

   initial begin
      int sc0;
      rst_n = 1'b0;
      drive(0, 0, 0, 0, 0, 0, 0);
      #1;
      check("reset_state",  {30'd0, state_o}, 32'd0);
      check("reset_pcw",    {31'd0, pc_write}, 32'd1);
      check("reset_stalls", 32'(stall_count), 32'd0);
      do_reset();

      // lw x5 ; add x6,x5,x1 -> single stall, then forward from MEM/WB
      drive(1, 1, 0, 5, 1, 1, 0); cycle();
      drive(1, 5, 1, 6, 0, 1, 0);
      #1;
      check("lu_pc_write", {31'd0, pc_write},    32'd0);
      check("lu_id_ex",    {31'd0, id_ex_flush}, 32'd1);
      cycle();
      check("lu_state",    {30'd0, state_o},     32'd1);
      check("lu_stalls",   32'(stall_count),     32'd1);
      cycle();
      check("lu_fwd_a",    {30'd0, fwd_a_ex},    32'd1);
      check("lu_no_again", 32'(stall_count),     32'd1);
      check("lu_run",      {30'd0, state_o},     32'd0);

      // add x5 ; sub x7,x5,x5 -> no stall, both operands from EX/MEM
      drive(1, 1, 2, 5, 0, 1, 0); cycle();
      drive(1, 5, 5, 7, 0, 1, 0); cycle();
      check("alu_fwd_a",   {30'd0, fwd_a_ex},    32'd2);
      check("alu_fwd_b",   {30'd0, fwd_b_ex},    32'd2);
      check("alu_stalls",  32'(stall_count),     32'd1);

      // branch together with load-use: flush wins
      drive(1, 1, 0, 5, 1, 1, 0); cycle();
      sc0 = stalls_m;
      drive(1, 5, 0, 6, 0, 1, 1);
      #1;
      check("br_if_flush", {31'd0, if_id_flush}, 32'd1);
      check("br_id_flush", {31'd0, id_ex_flush}, 32'd1);
      check("br_pc_write", {31'd0, pc_write},    32'd1);
      cycle();
      check("br_state",    {30'd0, state_o},     32'd2);
      check("br_flushes",  32'(flush_count),     32'd1);
      check("br_stalls",   32'(stall_count),     32'(sc0));

      // lw x0 ; use of x0 -> no hazard, no forwarding
      drive(1, 1, 0, 0, 1, 1, 0); cycle();
      drive(1, 0, 0, 8, 0, 1, 0);
      #1;
      check("x0_pc_write", {31'd0, pc_write},    32'd1);
      cycle();
      check("x0_fwd_a",    {30'd0, fwd_a_ex},    32'd0);
      check("x0_fwd_b",    {30'd0, fwd_b_ex},    32'd0);

      // counter saturation on the 2-bit instance: 2 events -> max-1, 3 more hold
      do_reset();
      repeat (2) load_use_event();
      check("sat_premax",  32'(s_stall_count), 32'd2);
      repeat (3) load_use_event();
      check("sat_hold",    32'(s_stall_count), 32'd3);
      check("sat_wide",    32'(stall_count),   32'd5);

      // reset asserted mid-stall, with a branch pending
      drive(1, 1, 0, 5, 1, 1, 0); cycle();
      drive(1, 5, 0, 6, 0, 1, 0); cycle();
      check("rs_in_stall", {30'd0, state_o}, 32'd1);
      rst_n = 1'b0;
      branch_taken_ex = 1'b1;
      #1;
      check("rs_state",    {30'd0, state_o},     32'd0);
      check("rs_pc_write", {31'd0, pc_write},    32'd1);
      check("rs_ifid_w",   {31'd0, if_id_write}, 32'd1);
      check("rs_if_flush", {31'd0, if_id_flush}, 32'd0);
      check("rs_id_flush", {31'd0, id_ex_flush}, 32'd0);
      check("rs_stalls",   32'(stall_count),     32'd0);
      model_reset();
      cycle();
      rst_n = 1'b1;
      drive(1, 5, 0, 6, 0, 1, 0);
      #1;
      check("rs_no_stall", {31'd0, pc_write},    32'd1);
      cycle();

      // randomized traffic on a small register window to provoke hazards
      for (int i = 0; i < 400; i++) begin
         drive(($urandom_range(0, 9) != 0),
               int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
               int'($urandom_range(0, 7)),
               ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) != 0),
               ($urandom_range(0, 9) == 0));
         cycle();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/hazard_unit.md
HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 SHALL have parameter `reg_bits`, default 5: register-index width.
REQ-002 SHALL have parameter `cnt_bits`, default 16: event-counter width.
REQ-003 SHALL have port `clk`, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port `rst_n`, input, 1: reset, asynchronous and active-low.
REQ-005 SHALL have port `valid_id`, input, 1: the ID-stage instruction is real (not a bubble).
REQ-006 SHALL have ports `rs1_id` and `rs2_id`, input, `reg_bits` each: ID-stage source registers.
REQ-007 SHALL have port `rd_id`, input, `reg_bits`: ID-stage destination register.
REQ-008 SHALL have ports `mem_read_id` and `reg_write_id`, input, 1 each: ID-stage control bits.
REQ-009 SHALL have port `branch_taken_ex`, input, 1: branch/jump resolved taken in EX.
REQ-010 SHALL have port `pc_write`, output, 1: PC update enable.
REQ-011 SHALL have port `if_id_write`, output, 1: IF/ID hold when 0.
REQ-012 SHALL have ports `if_id_flush` and `id_ex_flush`, output, 1 each: replace stage contents with a bubble.
REQ-013 SHALL have ports `fwd_a_ex` and `fwd_b_ex`, output, 2 each, registered and aligned with ID/EX outputs: 00 = register file, 10 = EX/MEM result, 01 = MEM/WB result.
REQ-014 SHALL have port `state_o`, output, 2: FSM state (00 RUN, 01 STALL, 10 FLUSH).
REQ-015 SHALL have ports `stall_count` and `flush_count`, output, `cnt_bits` each: saturating event counters.

Function
REQ-016 SHALL keep shadow stage records EX{valid,rd,mem_read,reg_write} and MEM{valid,rd,reg_write}.
REQ-017 SHALL raise load_use = `valid_id` & EX.valid & EX.mem_read & EX.rd!=0 & (EX.rd==`rs1_id` | EX.rd==`rs2_id`).
REQ-018 SHALL give `branch_taken_ex` priority over load_use in the same cycle.
REQ-019 SHALL, on branch (combinational, same cycle): `if_id_flush`=1, `id_ex_flush`=1, `pc_write`=1, `if_id_write`=1.
REQ-020 SHALL, on load_use without branch (same cycle): `pc_write`=0, `if_id_write`=0, `id_ex_flush`=1, `if_id_flush`=0.
REQ-021 SHALL otherwise drive `pc_write`=1, `if_id_write`=1 and both flushes 0.
REQ-022 SHALL move MEM <= EX on every rising edge.
REQ-023 SHALL load EX with the ID fields, EX.valid = `valid_id`, when neither branch nor load_use holds.
REQ-024 SHALL clear EX.valid (bubble) on branch or load_use.
REQ-025 SHALL compute the forwarding select for rs1 as 10 if EX.valid & EX.reg_write & EX.rd!=0 & EX.rd==`rs1_id`; else 01 if the same test holds for MEM; else 00.
REQ-026 SHALL apply REQ-025 identically to rs2 for `fwd_b_ex`.
REQ-027 SHALL register the REQ-025/REQ-026 selects into `fwd_a_ex`/`fwd_b_ex` when EX loads from ID, and register 00 when a bubble is inserted.
REQ-028 SHALL, in the FSM, go RUN->FLUSH on branch.
REQ-029 SHALL, in the FSM, go RUN->STALL on load_use.
REQ-030 SHALL, in the FSM, go STALL->FLUSH on branch, else STALL->RUN.
REQ-031 SHALL, in the FSM, go FLUSH->FLUSH on branch, else FLUSH->RUN.
REQ-032 SHALL make every stall or flush last exactly one cycle, with no repeat stall for the same load (the EX bubble guarantees this).
REQ-033 SHALL increment `stall_count` once per load_use cycle and `flush_count` once per branch cycle.
REQ-034 SHALL saturate both counters at all-ones, with no wrap.
REQ-035 SHALL treat rd=x0 as never hazardous and never forwarded.

Reset
REQ-036 SHALL, while `rst_n`=0, force state RUN, all shadow valids 0, `fwd_a_ex`=`fwd_b_ex`=00, counters 0, `pc_write`=1, `if_id_write`=1, flushes 0.
REQ-037 SHALL take effect immediately on `rst_n` falling edge, mid-stall or mid-flush included, with no pending bubble on release.
REQ-038 SHALL ignore `branch_taken_ex` while `rst_n`=0.

Verification
REQ-039 SHALL cover: lw x5 then add x6,x5,x1 -> one cycle with `pc_write`=0, `id_ex_flush`=1, `state_o`=01, `stall_count`=1; next cycle `fwd_a_ex`=01.
REQ-040 SHALL cover: add x5 then sub x7,x5,x5 -> no stall, `fwd_a_ex`=`fwd_b_ex`=10.
REQ-041 SHALL cover: `branch_taken_ex`=1 together with load_use -> both flushes 1, `pc_write`=1, `state_o`=10, `flush_count`=1, `stall_count` unchanged.
REQ-042 SHALL cover: lw x0 followed by a use of x0 -> no stall, forwarding 00.
REQ-043 SHALL cover: preload `stall_count` to all-ones minus 1, then three load-use events -> count holds at all-ones.
REQ-044 SHALL cover: `rst_n` asserted during STALL -> outputs reach reset values before the next edge; first instruction after release is not stalled.
